// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational ROM address, and a registered
// instruction/PC pair for decode with branch redirect and HALT freeze.
module fetch_unit #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [7:0] HALT_OP    = 8'b10001000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] start_pc_i,
  output logic [7:0] instr_addr_o,
  input  logic [7:0] instr_data_i,
  input  logic       stall_i,
  input  logic       branch_taken_i,
  input  logic       branch_back_i,
  input  logic [7:0] branch_off_i,
  output logic [7:0] instr_o,
  output logic [7:0] instr_pc_o,
  output logic       instr_valid_o,
  output logic       halted_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] instr_q;
  logic [7:0] instr_pc_q;
  logic       valid_q;
  logic       halted_q;
  logic [7:0] br_target;

  // Branch distance is relative to the instruction being resolved, not the PC.
  assign br_target = branch_back_i ? (instr_pc_q - branch_off_i)
                                   : (instr_pc_q + 8'd1 + branch_off_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= START_ADDR;
      instr_q    <= 8'd0;
      instr_pc_q <= 8'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else if (start_i) begin
      state_q  <= S_RUN;
      pc_q     <= start_pc_i;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!stall_i) begin
            if (branch_taken_i && valid_q) begin
              pc_q    <= br_target;
              valid_q <= 1'b0;
            end else begin
              instr_q    <= instr_data_i;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              if (instr_data_i == HALT_OP) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end else begin
                pc_q <= pc_q + 8'd1;
              end
            end
          end
        end
        S_HALT: begin
          // HALT byte is handed to decode once, then the stage goes quiet.
          if (!stall_i) valid_q <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_addr_o  = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/branch/start traffic
// compared every cycle against a rule-level reference model.
module tb_fetch_unit;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] start_pc_i;
  logic [7:0] instr_addr_o;
  logic [7:0] instr_data_i;
  logic       stall_i;
  logic       branch_taken_i;
  logic       branch_back_i;
  logic [7:0] branch_off_i;
  logic [7:0] instr_o;
  logic [7:0] instr_pc_o;
  logic       instr_valid_o;
  logic       halted_o;

  localparam logic [7:0] HALT = 8'b10001000;

  logic [7:0] rom [256];
  assign instr_data_i = rom[instr_addr_o];

  fetch_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .start_pc_i(start_pc_i),
    .instr_addr_o(instr_addr_o), .instr_data_i(instr_data_i), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_back_i(branch_back_i),
    .branch_off_i(branch_off_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int         m_mode;
  logic [7:0] m_pc, m_ir, m_ipc;
  logic       m_v, m_h;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 8'd0; m_ir = 8'd0; m_ipc = 8'd0; m_v = 1'b0; m_h = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},   instr_addr_o,         m_pc);
    check({tag, ".instr"},  instr_o,              m_ir);
    check({tag, ".ipc"},    instr_pc_o,           m_ipc);
    check({tag, ".valid"},  {7'd0, instr_valid_o}, {7'd0, m_v});
    check({tag, ".halted"}, {7'd0, halted_o},      {7'd0, m_h});
  endtask

  // One clock: evaluate the rules on the current inputs, advance, compare.
  task automatic step(input string tag);
    logic [7:0] fetched;
    if (start_i) begin
      m_pc = start_pc_i; m_v = 1'b0; m_h = 1'b0; m_mode = 1;
    end else if (m_mode == 1 && !stall_i) begin
      if (branch_taken_i && m_v) begin
        m_pc = branch_back_i ? m_ipc - branch_off_i : m_ipc + 8'd1 + branch_off_i;
        m_v  = 1'b0;
      end else begin
        fetched = rom[m_pc];
        m_ir = fetched; m_ipc = m_pc; m_v = 1'b1;
        if (fetched == HALT) begin
          m_mode = 2; m_h = 1'b1;
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
    end else if (m_mode == 2 && !stall_i) begin
      m_v = 1'b0;
    end
    @(posedge clk_i);
    #1;
    compare_all(tag);
  endtask

  task automatic launch(input logic [7:0] pc);
    start_i = 1'b1; start_pc_i = pc;
    step("start");
    start_i = 1'b0;
  endtask

  task automatic branch(input logic back, input logic [7:0] off);
    branch_taken_i = 1'b1; branch_back_i = back; branch_off_i = off;
    step("branch");
    branch_taken_i = 1'b0;
  endtask

  initial begin
    logic [7:0] held_ir, held_ipc;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i] == HALT) rom[i] = 8'h55;
    end
    rom[0] = 8'b11000001; rom[1] = 8'b10010000;
    rom[92] = HALT; rom[93] = 8'b11000110; rom[40] = 8'hFF;

    rst_ni = 1'b0; start_i = 1'b0; start_pc_i = 8'd0; stall_i = 1'b0;
    branch_taken_i = 1'b0; branch_back_i = 1'b0; branch_off_i = 8'd0;
    model_reset();
    #12;
    compare_all("reset");
    rst_ni = 1'b1;
    step("idle0"); step("idle1");

    // Launch from 0 and check the known ROM head.
    launch(8'd0);
    check("launch.valid_bubble", {7'd0, instr_valid_o}, 8'd0);
    step("run");
    check("launch.c1_instr", instr_o, 8'b11000001);
    check("launch.c1_pc", instr_pc_o, 8'd0);
    step("run");
    check("launch.c2_instr", instr_o, 8'b10010000);
    check("launch.c2_pc", instr_pc_o, 8'd1);
    check("launch.pc", instr_addr_o, 8'd2);
    step("run"); step("run");

    // Forward branch from 17 by 6.
    launch(8'd17);
    step("run");
    check("fwd.at17", instr_pc_o, 8'd17);
    branch(1'b0, 8'd6);
    check("fwd.bubble", {7'd0, instr_valid_o}, 8'd0);
    step("run");
    check("fwd.target", instr_pc_o, 8'd24);

    // Backward branches, including wrap below zero.
    launch(8'd126);
    step("run");
    branch(1'b1, 8'd25);
    step("run");
    check("back.target", instr_pc_o, 8'd101);
    launch(8'd5);
    step("run");
    branch(1'b1, 8'd10);
    step("run");
    check("back.wrap", instr_pc_o, 8'd251);
    for (int i = 0; i < 6; i++) step("wrap_run");
    check("wrap.pc_past_255", instr_pc_o, 8'd1);

    // Three-cycle stall with a branch pulse in the middle.
    held_ir = instr_o; held_ipc = instr_pc_o;
    stall_i = 1'b1;
    step("stall");
    branch_taken_i = 1'b1; branch_back_i = 1'b0; branch_off_i = 8'd50;
    step("stall");
    branch_taken_i = 1'b0;
    step("stall");
    check("stall.instr", instr_o, held_ir);
    check("stall.ipc", instr_pc_o, held_ipc);
    check("stall.pc", instr_addr_o, held_ipc + 8'd1);
    stall_i = 1'b0;
    step("unstall");
    check("unstall.ipc", instr_pc_o, held_ipc + 8'd1);

    // HALT from 88.
    launch(8'd88);
    for (int i = 0; i < 5; i++) step("to_halt");
    check("halt.instr", instr_o, HALT);
    check("halt.ipc", instr_pc_o, 8'd92);
    check("halt.valid", {7'd0, instr_valid_o}, 8'd1);
    step("halted");
    check("halt.halted", {7'd0, halted_o}, 8'd1);
    check("halt.valid_clr", {7'd0, instr_valid_o}, 8'd0);
    branch(1'b0, 8'd3);
    step("halted");
    check("halt.pc_frozen", instr_addr_o, 8'd92);
    launch(8'd93);
    check("resume.halted_clr", {7'd0, halted_o}, 8'd0);
    step("resume");
    check("resume.instr", instr_o, 8'b11000110);
    check("resume.ipc", instr_pc_o, 8'd93);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall_i        = ($urandom_range(0, 3) == 0);
      branch_taken_i = ($urandom_range(0, 4) == 0);
      branch_back_i  = 1'($urandom_range(0, 1));
      branch_off_i   = 8'($urandom_range(0, 255));
      start_i        = ($urandom_range(0, 24) == 0);
      start_pc_i     = ($urandom_range(0, 3) == 0) ? 8'd88 : 8'($urandom_range(0, 255));
      step("rand");
    end
    stall_i = 1'b0; branch_taken_i = 1'b0; start_i = 1'b0;

    // Asynchronous reset between edges.
    launch(8'd30);
    step("run"); step("run");
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_rst_idle"); step("post_rst_idle");
    check("post_rst.valid", {7'd0, instr_valid_o}, 8'd0);
    launch(8'd0);
    step("post_rst_run");
    check("post_rst.instr", instr_o, 8'b11000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 8-bit single-issue core. Holds the program counter, drives the address of the combinational 256-entry instruction ROM, and registers the returned byte into an instruction register for the decoder. Redirects on taken forward/backward branches reported by execute, and stops on the HALT encoding. The start address is selectable, so programs at 0, 93 and 138 can each be launched.

## Interface
- `START_ADDR`, default 8'd0: PC value loaded on reset.
- `HALT_OP`, default 8'b10001000: encoding that stops fetch.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle pulse; loads PC from `start_pc_i` and enters RUN.
- `start_pc_i`  in  8  first instruction address of the program to launch.
- `instr_addr_o`  out  8  ROM address; equals the PC register.
- `instr_data_i`  in  8  ROM data for `instr_addr_o`, valid in the same cycle.
- `stall_i`  in  1  downstream not ready; hold PC and instruction register.
- `branch_taken_i`  in  1  execute resolved the instruction in `instr_o` as a taken branch.
- `branch_back_i`  in  1  0: forward (`branch`), 1: backward (`branchb`).
- `branch_off_i`  in  8  unsigned branch distance (register value).
- `instr_o`  out  8  registered instruction for decode.
- `instr_pc_o`  out  8  address that `instr_o` was fetched from.
- `instr_valid_o`  out  1  `instr_o` holds a live instruction.
- `halted_o`  out  1  HALT has been issued; fetch is frozen.

## Operation
- **States.** IDLE, RUN, HALT. On reset the unit is in IDLE.
- **Reset values.** PC = `START_ADDR`; `instr_o` = 0; `instr_pc_o` = 0; `instr_valid_o` = 0; `halted_o` = 0.
- **IDLE.** PC holds and `instr_valid_o` is 0. On `start_i`: PC ← `start_pc_i`, go to RUN.
- **RUN, no stall, no taken branch.**
  - `instr_o` ← `instr_data_i` and `instr_pc_o` ← PC.
  - `instr_valid_o` ← 1 and PC ← PC+1, mod 256, so 255 wraps to 0.
- **RUN, stall.** `stall_i`=1 holds PC, `instr_o`, `instr_pc_o` and `instr_valid_o`. `branch_taken_i` is ignored while stalled.
- **Taken branch.** Applies when `branch_taken_i` and `instr_valid_o` are both high and `stall_i` is low.
  - Forward target = `instr_pc_o` + 1 + `branch_off_i`.
  - Backward target = `instr_pc_o` − `branch_off_i`.
  - Both use 8-bit mod-256 arithmetic; no overflow flag.
  - PC ← target and `instr_valid_o` ← 0, which squashes the wrong-path byte fetched this cycle. The target instruction appears on the following cycle.
- **`branch_taken_i` with `instr_valid_o`=0.** Ignored.
- **HALT fetch.** When an unstalled RUN cycle fetches `instr_data_i` == `HALT_OP`:
  - The HALT byte is registered normally with `instr_valid_o`=1.
  - PC is not incremented and the state goes to HALT.
- **HALT state.**
  - `halted_o` = 1.
  - `instr_valid_o` clears on the first non-stalled cycle, so HALT is delivered exactly once.
  - PC is frozen. Only `start_i` or reset leave HALT.
- **Priority.** Reset > `start_i` > branch redirect > HALT detection > normal advance.
  - A taken branch in the same cycle that fetches HALT_OP redirects; HALT is not entered.
- **`start_i` in any state.**
  - PC ← `start_pc_i` and `instr_valid_o` ← 0.
  - `halted_o` ← 0 and the state goes to RUN; any in-flight instruction is discarded.
- **Out-of-range ROM data.** The 0xFF default is passed through as a normal instruction; it is not treated specially.

## Timing
- **ROM access.** `instr_addr_o` is a direct register output, and the ROM is combinational.
- **Fetch latency.** One cycle from PC to `instr_o`.
- **After `start_i` at edge N.** The first valid instruction is registered at edge N+1.
- **Branch penalty.** One bubble cycle.
- **Asynchronous reset.** Deassertion is clean. Asserting `rst_ni` mid-RUN immediately forces all reset values with no clock.
- **Throughput.** One instruction per cycle with no stall or branch.

## Test plan
- **Reset and launch.** Reset, then pulse `start_i` with `start_pc_i`=0 against the real ROM contents. Required: cycle 1 `instr_o`=8'b11000001 with `instr_pc_o`=0; cycle 2 `instr_o`=8'b10010000 with `instr_pc_o`=1; PC increments each cycle.
- **Forward branch.** `instr_pc_o`=17, `branch_taken_i`=1, `branch_back_i`=0, `branch_off_i`=6. Required: one cycle with `instr_valid_o`=0, then `instr_pc_o`=24.
- **Backward branch and wrap.** `instr_pc_o`=126, backward, off=25 → next `instr_pc_o`=101. `instr_pc_o`=5, backward, off=10 → 251.
- **Stall.** Hold `stall_i` high for 3 cycles mid-run. Required: `instr_o`, `instr_pc_o` and PC unchanged, and a `branch_taken_i` pulse during the stall causes no redirect.
- **Halt.** Run from 88. Required: `instr_o`=8'b10001000 at `instr_pc_o`=92 with valid for one cycle, then `halted_o`=1, valid=0, PC=92 held. A later `start_i` with `start_pc_i`=93 resumes and fetches 8'b11000110.
- **Asynchronous reset mid-run.** Drop `rst_ni` between clock edges. Required: all outputs return to reset values before the next edge, and the state is IDLE.
